// File: rtl/ha_token_join_if.sv
// Handshake bundle for the two-input token join.
// The producer ports, the joined output port and the status counters.
interface ha_token_join_if #(
  parameter int DataIn_BW = 32,
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 16
);
  logic [DataIn_BW-1:0] DataIn_0;
  logic                 DataIn_0_Valid;
  logic                 DataIn_0_Ready;
  logic [DataIn_BW-1:0] DataIn_1;
  logic                 DataIn_1_Valid;
  logic                 DataIn_1_Ready;
  logic [DataIn_BW-1:0] DataOut_0;
  logic [DataIn_BW-1:0] DataOut_1;
  logic                 DataOut_Valid;
  logic                 DataOut_Ready;
  logic [ADDR_W:0]      Occ_0;
  logic [ADDR_W:0]      Occ_1;
  logic [CNT_W-1:0]     Tok_Count;

  modport slave (
    input  DataIn_0, DataIn_0_Valid, DataIn_1, DataIn_1_Valid, DataOut_Ready,
    output DataIn_0_Ready, DataIn_1_Ready, DataOut_0, DataOut_1, DataOut_Valid,
           Occ_0, Occ_1, Tok_Count
  );

  modport master (
    output DataIn_0, DataIn_0_Valid, DataIn_1, DataIn_1_Valid, DataOut_Ready,
    input  DataIn_0_Ready, DataIn_1_Ready, DataOut_0, DataOut_1, DataOut_Valid,
           Occ_0, Occ_1, Tok_Count
  );
endinterface

// File: rtl/ha_token_join.sv
// Two-input token join: each producer feeds its own elastic FIFO, and a joined
// token carrying both head words fires once both FIFOs are non-empty.
module ha_token_join #(
  parameter int DataIn_BW = 32,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           rst,
  ha_token_join_if.slave bus
);
  localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W+1)'(DEPTH);

  logic [DataIn_BW-1:0] mem [2][DEPTH];
  logic [ADDR_W-1:0]    wr_ptr [2];
  logic [ADDR_W-1:0]    rd_ptr [2];
  logic [ADDR_W:0]      occ [2];
  logic [DataIn_BW-1:0] din [2];
  logic [1:0]           din_valid;
  logic [1:0]           ready;
  logic [1:0]           push;
  logic                 out_valid;
  logic                 fire;
  logic [CNT_W-1:0]     tok_count;

  assign din[0]       = bus.DataIn_0;
  assign din[1]       = bus.DataIn_1;
  assign din_valid[0] = bus.DataIn_0_Valid;
  assign din_valid[1] = bus.DataIn_1_Valid;

  // Ready looks only at registered occupancy, so a full FIFO cannot take a
  // token in the same cycle it is popped.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ready[s] = (occ[s] != OCC_FULL) & rst;
      push[s]  = din_valid[s] & ready[s];
    end
  end

  assign out_valid = (occ[0] != '0) & (occ[1] != '0);
  assign fire      = out_valid & bus.DataOut_Ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < DEPTH; i++) mem[s][i] <= '0;
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        occ[s]    <= '0;
      end
      tok_count <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          mem[s][wr_ptr[s]] <= din[s];
          wr_ptr[s]         <= wr_ptr[s] + 1'b1;
        end
        if (fire) rd_ptr[s] <= rd_ptr[s] + 1'b1;
        occ[s] <= occ[s] + {{ADDR_W{1'b0}}, push[s]} - {{ADDR_W{1'b0}}, fire};
      end
      if (fire) tok_count <= tok_count + 1'b1;
    end
  end

  assign bus.DataIn_0_Ready = ready[0];
  assign bus.DataIn_1_Ready = ready[1];
  assign bus.DataOut_0      = mem[0][rd_ptr[0]];
  assign bus.DataOut_1      = mem[1][rd_ptr[1]];
  assign bus.DataOut_Valid  = out_valid;
  assign bus.Occ_0          = occ[0];
  assign bus.Occ_1          = occ[1];
  assign bus.Tok_Count      = tok_count;

  a_no_push_full_0 : assert property (@(posedge clk) disable iff (!rst) !(push[0] && occ[0] == OCC_FULL));
  a_no_push_full_1 : assert property (@(posedge clk) disable iff (!rst) !(push[1] && occ[1] == OCC_FULL));
  a_no_pop_empty_0 : assert property (@(posedge clk) disable iff (!rst) !(fire && occ[0] == '0));
  a_no_pop_empty_1 : assert property (@(posedge clk) disable iff (!rst) !(fire && occ[1] == '0));
endmodule
